maq_hm: RTL
===========

# maq_hm

Minutes/hours stage of the clock. Consumes the minute-carry flag from the seconds stage and keeps the time of day as BCD minutes (00–59) and hours (00–23). It provides a button-driven time-set mode and emits a one-cycle day-rollover pulse. Its outputs feed the display multiplexer.

## Interface

Parameters:
- none. Ranges are fixed by package constants.

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- incrementa_minuto  in  1  level from seconds stage; each 0→1 transition is one minute
- btn_modo  in  1  debounced, synchronous level; each 0→1 advances the mode
- btn_inc  in  1  debounced, synchronous level; each 0→1 increments the selected field in set mode
- bcd_m_lsd  out  4  minutes units, 0–9
- bcd_m_msd  out  3  minutes tens, 0–5
- bcd_h_lsd  out  4  hours units, 0–9 (0–3 when tens = 2)
- bcd_h_msd  out  2  hours tens, 0–2
- modo  out  2  current state encoding, for display blinking
- incrementa_dia  out  1  one-cycle pulse on 23:59→00:00 rollover in RUN
- zera_segundos  out  1  one-cycle pulse on SET_M→RUN exit

## Operation

- Edge detection:
  - Each of the three inputs has a previous-value register, reset to 1.
  - rise = in & ~prev.
  - An input already high when reset releases produces no event.
- States (estado_t): RUN, SET_H, SET_M.
  - On rise(btn_modo): RUN→SET_H→SET_M→RUN. No other transitions.
- RUN:
  - On rise(incrementa_minuto), advance minutes.
  - m_lsd 9→0 carries into m_msd.
  - m_msd:m_lsd 5:9→0:0 carries into hours.
  - Hours h_lsd 9→0 with h_msd+1.
  - At 2:3 with a minute carry, hours go to 0:0 and incrementa_dia pulses.
  - rise(btn_inc) is ignored in RUN.
- SET_H:
  - rise(btn_inc) increments hours 23→00 with no day pulse.
  - Minute ticks are ignored; time is frozen.
- SET_M:
  - rise(btn_inc) increments minutes 59→00 with no carry into hours.
  - Minute ticks are ignored.
- Exit SET_M→RUN: zera_segundos pulses high in the same cycle modo becomes RUN.
- Simultaneous events:
  - Each event's action uses the state held before the edge.
  - rise(btn_modo) and rise(incrementa_minuto) in RUN: minute advances and state goes to SET_H.
  - rise(btn_modo) and rise(btn_inc) in SET_H: hour increments, then state goes to SET_M.
- Outputs hold only legal BCD codes. No illegal value is ever reachable.

## Timing

- All outputs are registered.
- Reset values: all BCD fields 0 (00:00); modo = RUN (2'd0); incrementa_dia = 0; zera_segundos = 0; prev registers = 1.
- Latency: for an input sampled high at edge k with prev low, counters and state update at edge k; new values are visible during cycle k..k+1.
- incrementa_dia and zera_segundos are high for exactly one cycle.
- Reset mid-operation, including during a set state, returns to RUN at 00:00 on the next edge, with no pulses.
- An input held high for many cycles counts once. A new event requires a return to 0 for at least one cycle.
- modo encoding: RUN=0, SET_H=1, SET_M=2. Code 3 is unreachable; if reached, return to RUN.

## Structure

- Shared package relogio_pkg holds:
  - estado_t enum.
  - Constants MIN_MSD_MAX=5, LSD_MAX=9, HORA_MSD_MAX=2, HORA_LSD_MAX_EM_2=3.
- The seconds stage uses the same package.
- One sub-module, detector_borda (rising-edge detector with reset-to-1 prev register), is instantiated three times.
- Counter and FSM logic stay in maq_hm.

## Test plan

- Reset with all inputs high, then hold 10 cycles → 00:00, modo=0, no pulses, no counting.
- Preload to 00:59 with 59 ticks; one tick → 01:00. Hold the tick high 5 cycles → still 01:00.
- Drive to 23:59; one tick → 00:00 with incrementa_dia high exactly 1 cycle.
- btn_modo → modo=1; btn_inc ×25 → hours 01, minutes unchanged; ticks during SET_H leave time unchanged.
- btn_modo → modo=2; btn_inc ×61 from 00 → minutes 01, hours unchanged. btn_modo → modo=0 with zera_segundos high 1 cycle.
- Simultaneous btn_modo and tick rise in RUN at 12:34 → 12:35 and modo=1. Assert reset while in SET_M → 00:00, modo=0 next edge.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared definitions for the clock stages: FSM state type and BCD digit limits.
package relogio_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } estado_t;

  localparam int MIN_MSD_MAX       = 5;
  localparam int LSD_MAX           = 9;
  localparam int HORA_MSD_MAX      = 2;
  localparam int HORA_LSD_MAX_EM_2 = 3;

endpackage

// File: rtl/maq_hm_detector_borda.sv
// Rising-edge detector. The previous-value register resets to 1 so an input
// already high when reset releases does not count as an event.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic r_prev;

  always_ff @(posedge clock) begin
    if (reset) r_prev <= 1'b1;
    else       r_prev <= sinal;
  end

  assign borda = sinal & ~r_prev;

endmodule

// File: rtl/maq_hm.sv
// Minutes/hours stage: BCD time of day, button-driven set mode, day-rollover
// and seconds-clear pulses.
//
// state | meaning
// RUN   | minute ticks advance the time; day pulse on 23:59 -> 00:00
// SET_H | btn_inc advances hours (23 -> 00, no day pulse); time frozen
// SET_M | btn_inc advances minutes (59 -> 00, no hour carry); leaving clears seconds
module maq_hm
  import relogio_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       incrementa_minuto,
  input  logic       btn_modo,
  input  logic       btn_inc,
  output logic [3:0] bcd_m_lsd,
  output logic [2:0] bcd_m_msd,
  output logic [3:0] bcd_h_lsd,
  output logic [1:0] bcd_h_msd,
  output logic [1:0] modo,
  output logic       incrementa_dia,
  output logic       zera_segundos
);

  logic       w_rise_min, w_rise_modo, w_rise_inc;
  logic [7:0] w_min_prox;
  logic [5:0] w_hora_prox;
  logic       w_fim_dia;

  estado_t    r_estado;
  logic [3:0] r_m_lsd;
  logic [2:0] r_m_msd;
  logic [3:0] r_h_lsd;
  logic [1:0] r_h_msd;
  logic       r_dia;
  logic       r_zera;

  detector_borda u_borda_min  (.clock(clock), .reset(reset), .sinal(incrementa_minuto), .borda(w_rise_min));
  detector_borda u_borda_modo (.clock(clock), .reset(reset), .sinal(btn_modo),          .borda(w_rise_modo));
  detector_borda u_borda_inc  (.clock(clock), .reset(reset), .sinal(btn_inc),           .borda(w_rise_inc));

  // Result is {carry_to_hours, msd, lsd}.
  function automatic logic [7:0] prox_min(input logic [2:0] msd, input logic [3:0] lsd);
    if (lsd != 4'(LSD_MAX))          return {1'b0, msd, lsd + 4'd1};
    else if (msd != 3'(MIN_MSD_MAX)) return {1'b0, msd + 3'd1, 4'd0};
    else                             return 8'h80;
  endfunction

  function automatic logic [5:0] prox_hora(input logic [1:0] msd, input logic [3:0] lsd);
    if (msd == 2'(HORA_MSD_MAX) && lsd == 4'(HORA_LSD_MAX_EM_2)) return 6'd0;
    else if (lsd == 4'(LSD_MAX))                                 return {msd + 2'd1, 4'd0};
    else                                                         return {msd, lsd + 4'd1};
  endfunction

  assign w_min_prox  = prox_min(r_m_msd, r_m_lsd);
  assign w_hora_prox = prox_hora(r_h_msd, r_h_lsd);
  assign w_fim_dia   = (r_h_msd == 2'(HORA_MSD_MAX)) && (r_h_lsd == 4'(HORA_LSD_MAX_EM_2));

  // Each action uses the state held before the edge, so a mode press in the
  // same cycle as a tick or increment still lets that event land first.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= RUN;
      r_m_lsd  <= '0;
      r_m_msd  <= '0;
      r_h_lsd  <= '0;
      r_h_msd  <= '0;
      r_dia    <= 1'b0;
      r_zera   <= 1'b0;
    end else begin
      r_dia  <= 1'b0;
      r_zera <= 1'b0;
      case (r_estado)
        RUN: begin
          if (w_rise_min) begin
            {r_m_msd, r_m_lsd} <= w_min_prox[6:0];
            if (w_min_prox[7]) begin
              {r_h_msd, r_h_lsd} <= w_hora_prox;
              r_dia              <= w_fim_dia;
            end
          end
          if (w_rise_modo) r_estado <= SET_H;
        end
        SET_H: begin
          if (w_rise_inc)  {r_h_msd, r_h_lsd} <= w_hora_prox;
          if (w_rise_modo) r_estado <= SET_M;
        end
        SET_M: begin
          if (w_rise_inc) {r_m_msd, r_m_lsd} <= w_min_prox[6:0];
          if (w_rise_modo) begin
            r_estado <= RUN;
            r_zera   <= 1'b1;
          end
        end
        default: r_estado <= RUN;
      endcase
    end
  end

  assign bcd_m_lsd      = r_m_lsd;
  assign bcd_m_msd      = r_m_msd;
  assign bcd_h_lsd      = r_h_lsd;
  assign bcd_h_msd      = r_h_msd;
  assign modo           = r_estado;
  assign incrementa_dia = r_dia;
  assign zera_segundos  = r_zera;

endmodule
